// File: rtl/per2apb_bridge.sv
// Peripheral-interconnect slave to APB3 master bridge.
// Each granted request runs one APB setup/access transfer and returns a single r_valid response.
module per2apb_bridge #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ID_WIDTH       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic                      r_valid_q, r_valid_d;
  logic                      r_opc_q, r_opc_d;
  logic [31:0]               r_rdata_q, r_rdata_d;
  logic [ID_WIDTH-1:0]       r_id_q, r_id_d;

  assign per_slave_gnt_o = per_slave_req_i && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    id_d      = id_q;
    r_valid_d = 1'b0;
    r_opc_d   = r_opc_q;
    r_rdata_d = r_rdata_q;
    r_id_d    = r_id_q;

    case (state_q)
      IDLE: begin
        if (per_slave_req_i) begin
          if (per_slave_we_i && (per_slave_be_i != 4'hF)) begin
            // APB3 has no byte strobes: reject partial writes without touching the bus
            state_d   = RESP;
            r_valid_d = 1'b1;
            r_opc_d   = 1'b1;
            r_rdata_d = '0;
            r_id_d    = per_slave_id_i;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = per_slave_add_i[APB_ADDR_WIDTH-1:0];
            pwrite_d = per_slave_we_i;
            pwdata_d = per_slave_we_i ? per_slave_wdata_i : '0;
            id_d     = per_slave_id_i;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_valid_d = 1'b1;
          r_opc_d   = PSLVERR;
          r_rdata_d = pwrite_q ? '0 : PRDATA;
          r_id_d    = id_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      id_q      <= '0;
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_rdata_q <= '0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      id_q      <= id_d;
      r_valid_q <= r_valid_d;
      r_opc_q   <= r_opc_d;
      r_rdata_q <= r_rdata_d;
      r_id_q    <= r_id_d;
    end
  end

  assign PADDR               = paddr_q;
  assign PWDATA              = pwdata_q;
  assign PWRITE              = pwrite_q;
  assign PSEL                = psel_q;
  assign PENABLE             = penable_q;
  assign per_slave_r_valid_o = r_valid_q;
  assign per_slave_r_opc_o   = r_opc_q;
  assign per_slave_r_rdata_o = r_rdata_q;
  assign per_slave_r_id_o    = r_id_q;

endmodule

// File: tb/tb_per2apb_bridge.sv
// Bench for per2apb_bridge: directed scenarios plus randomized transfers checked
// against a transaction-level latency/response model.
module tb_per2apb_bridge;
  localparam int PAW = 32;
  localparam int AAW = 32;
  localparam int IDW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic [PAW-1:0]  add = '0;
  logic            we = 1'b0;
  logic [31:0]     wdata = '0;
  logic [3:0]      be = '0;
  logic [IDW-1:0]  id = '0;
  logic            gnt, r_valid, r_opc;
  logic [31:0]     r_rdata;
  logic [IDW-1:0]  r_id;
  logic [AAW-1:0]  paddr;
  logic [31:0]     pwdata;
  logic            pwrite, psel, penable;
  logic [31:0]     prdata = '0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  per2apb_bridge #(.PER_ADDR_WIDTH(PAW), .APB_ADDR_WIDTH(AAW), .ID_WIDTH(IDW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
    .per_slave_wdata_i(wdata), .per_slave_be_i(be), .per_slave_id_i(id),
    .per_slave_gnt_o(gnt), .per_slave_r_valid_o(r_valid), .per_slave_r_opc_o(r_opc),
    .per_slave_r_rdata_o(r_rdata), .per_slave_r_id_o(r_id),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  task automatic test_reset();
    req = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({psel, penable, pwrite, r_valid, r_opc} !== 5'b0 || paddr !== '0 || pwdata !== '0
        || r_rdata !== '0 || r_id !== '0) begin
      errors++;
      $display("FAIL reset_state: got psel=%b pen=%b pwr=%b rv=%b opc=%b paddr=%h pwd=%h rd=%h rid=%h, expected all 0",
               psel, penable, pwrite, r_valid, r_opc, paddr, pwdata, r_rdata, r_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction from an idle bridge; the model gives latency and response from the request alone.
  task automatic test_transfer(input logic t_we, input logic [PAW-1:0] t_add, input logic [31:0] t_wdata,
                               input logic [3:0] t_be, input logic [IDW-1:0] t_id, input int waits,
                               input logic [31:0] t_prdata, input logic t_err);
    logic        partial = t_we && (t_be != 4'hF);
    int          lat     = partial ? 1 : 3 + waits;
    logic [31:0] e_rdata = (t_we) ? 32'h0 : t_prdata;
    logic        e_opc   = partial | t_err;
    logic [AAW-1:0] e_addr = t_add[AAW-1:0];
    logic [31:0] e_pwdata = t_we ? t_wdata : 32'h0;
    logic        e_psel, e_pen, e_valid;

    req = 1'b1; add = t_add; we = t_we; wdata = t_wdata; be = t_be; id = t_id; pready = 1'b0;
    #1;
    vectors++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL gnt_idle: got %b expected 1 (id=%h)", gnt, t_id);
      req = 1'b0;
      @(negedge clk);
      return;
    end
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      req = 1'b0;
      add = $urandom; wdata = $urandom; we = $urandom_range(0, 1); id = $urandom;
      e_psel  = !partial && c >= 1 && c <= 2 + waits;
      e_pen   = !partial && c >= 2 && c <= 2 + waits;
      e_valid = (c == lat);
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = $urandom_range(0, 1);
      if (!partial && c == 2 + waits) begin
        pready = 1'b1; prdata = t_prdata; pslverr = t_err;
      end
      #1;
      vectors++;
      if (psel !== e_psel || penable !== e_pen || r_valid !== e_valid) begin
        errors++;
        $display("FAIL ctrl_c%0d id=%h: got psel=%b pen=%b rv=%b expected psel=%b pen=%b rv=%b",
                 c, t_id, psel, penable, r_valid, e_psel, e_pen, e_valid);
      end
      if (e_psel) begin
        vectors++;
        if (paddr !== e_addr || pwrite !== t_we || pwdata !== e_pwdata) begin
          errors++;
          $display("FAIL apb_bus_c%0d: got paddr=%h pwrite=%b pwdata=%h expected %h %b %h",
                   c, paddr, pwrite, pwdata, e_addr, t_we, e_pwdata);
        end
      end
      if (c >= lat) begin
        vectors++;
        if (r_rdata !== e_rdata || r_opc !== e_opc || r_id !== t_id) begin
          errors++;
          $display("FAIL resp_c%0d: got rdata=%h opc=%b id=%h expected %h %b %h",
                   c, r_rdata, r_opc, r_id, e_rdata, e_opc, t_id);
        end
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [IDW-1:0] ids[3] = '{8'h11, 8'h22, 8'h33};
    logic [IDW-1:0] pend[$];
    int issued = 0, done = 0, last_g = -100;
    bit adv = 0;
    req = 1'b1; we = 1'b0; be = 4'hF; add = 32'h4000_0000; id = ids[0]; pready = 1'b1;
    for (int cyc = 0; cyc < 40 && done < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (adv) begin
        adv = 0;
        if (issued < 3) begin id = ids[issued]; add = add + 32'h10; end
        else req = 1'b0;
      end
      prdata = (pend.size() > 0) ? {24'hC0FFEE, pend[0]} : 32'hBAD0_BAD0;
      #1;
      if (gnt && (psel || r_valid)) begin
        vectors++; errors++;
        $display("FAIL b2b_gnt_busy: got gnt=1 with psel=%b rv=%b expected gnt=0", psel, r_valid);
      end
      if (r_valid) begin
        vectors++;
        if (pend.size() == 0 || r_id !== pend[0] || r_rdata !== {24'hC0FFEE, pend[0]}) begin
          errors++;
          $display("FAIL b2b_resp: got id=%h rdata=%h expected id=%h", r_id, r_rdata,
                   (pend.size() > 0) ? pend[0] : 8'hxx);
        end
        if (pend.size() > 0) void'(pend.pop_front());
        done++;
      end
      if (gnt) begin
        if (issued > 0) begin
          vectors++;
          if (cyc - last_g != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 4", cyc - last_g);
          end
        end
        last_g = cyc; pend.push_back(id); issued++; adv = 1;
      end
    end
    vectors++;
    if (done != 3 || issued != 3) begin
      errors++;
      $display("FAIL b2b_count: got grants=%0d responses=%0d expected 3 3", issued, done);
    end
    @(negedge clk);
    req = 1'b0; pready = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    bit seen = 0;
    req = 1'b1; we = 1'b0; be = 4'hF; add = 32'h0000_0100; id = 8'h5A; pready = 1'b0;
    #1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    #1;
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_access: got psel=%b pen=%b expected 1 1", psel, penable);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got psel=%b pen=%b rv=%b expected 0 0 0", psel, penable, r_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; pready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (r_valid || psel) seen = 1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_lost: got r_valid/psel activity after reset expected none");
    end
    pready = 1'b0;
    test_transfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 8'h6B, 1, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic        r_we  = $urandom_range(0, 1);
      logic [3:0]  r_be  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      int          gap   = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      test_transfer(r_we, $urandom, $urandom, r_be, 8'($urandom), $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_transfer(1'b0, 32'h1A10_0004, 32'h0, 4'hF, 8'h3C, 0, 32'hDEAD_BEEF, 1'b0);
    test_transfer(1'b1, 32'h1A10_0008, 32'h1234_5678, 4'hF, 8'h41, 3, 32'hFFFF_FFFF, 1'b0);
    test_transfer(1'b0, 32'h1A10_000C, 32'h0, 4'hF, 8'h77, 1, 32'h0000_1111, 1'b1);
    test_transfer(1'b1, 32'h1A10_0010, 32'hAAAA_5555, 4'b0011, 8'h99, 0, 32'h0, 1'b0);
    @(negedge clk);
    test_back_to_back();
    test_reset_mid_transfer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
